// File: rtl/posit_extract_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : posit_extract_pipe_if
//  Description : Streaming bus for the posit decoder. Carries the posit word
//                in with valid/ready and the serialized value out with
//                valid/ready.
//                  in_posit  [NBITS] posit word           (master -> slave)
//                  in_valid           in_posit is valid    (master -> slave)
//                  in_ready           slave accepts word   (slave -> master)
//                  out_value [VAL_W] {sgn,scale,frac,inf,zero} (slave -> master)
//                  out_valid          out_value is valid   (slave -> master)
//                  out_ready          master accepts value (master -> slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface posit_extract_pipe_if #(
   parameter int NBITS = 32,
   parameter int VAL_W = 39
);
   logic [NBITS-1:0] in_posit;
   logic             in_valid;
   logic             in_ready;
   logic [VAL_W-1:0] out_value;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  in_posit, in_valid, out_ready,
      output in_ready, out_value, out_valid
   );

   modport master (
      output in_posit, in_valid, out_ready,
      input  in_ready, out_value, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/posit_extract_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : posit_extract_pipe
//  Description : Two-stage pipelined posit<NBITS,ES> decoder. Unpacks each
//                posit word into the serialized value
//                {sgn, scale[SCALE_W], fraction[FBITS], inf, zero}.
//                Stage 1 registers sign, special flags and magnitude; stage 2
//                registers the decoded regime/exponent/fraction.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                bus.slave  in_posit/in_valid/in_ready in,
//                           out_value/out_valid/out_ready out
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_extract_pipe #(
   parameter int NBITS   = 32,
   parameter int ES      = 2,
   parameter int SCALE_W = 9,
   parameter int FBITS   = 27
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   posit_extract_pipe_if.slave bus
);
   localparam int c_AW = NBITS - 1;           // magnitude width
   localparam int c_VW = SCALE_W + FBITS + 3; // serialized value width
   localparam int c_CW = $clog2(NBITS);       // run-length width (1..NBITS-1)
   localparam int c_RW = ES + FBITS;          // bits following the terminator

   // ---------------- stage 1 registers ----------------
   logic            r_s1_valid;
   logic            r_s1_sgn;
   logic            r_s1_zero;
   logic            r_s1_inf;
   logic [c_AW-1:0] r_s1_abs;

   // ---------------- stage 2 registers ----------------
   logic            r_s2_valid;
   logic [c_VW-1:0] r_s2_value;

   // ---------------- handshake ----------------
   logic w_s2_load;
   logic w_in_ready;
   logic w_in_fire;

   assign w_s2_load  = r_s1_valid & (~r_s2_valid | bus.out_ready);
   assign w_in_ready = ~r_s1_valid | w_s2_load;
   assign w_in_fire  = bus.in_valid & w_in_ready;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.out_value = r_s2_value;

   // ---------------- stage 1 datapath ----------------
   logic [c_AW-1:0] w_in_abs;
   logic            w_in_zero;
   logic            w_in_inf;

   assign w_in_abs  = bus.in_posit[NBITS-1] ? (~bus.in_posit[c_AW-1:0] + c_AW'(1))
                                            : bus.in_posit[c_AW-1:0];
   assign w_in_zero = (bus.in_posit == '0);
   assign w_in_inf  = (bus.in_posit == {1'b1, {c_AW{1'b0}}});

   // ---------------- stage 2 datapath (regime decode) ----------------
   logic               w_r;
   logic [c_AW-1:0]    w_run;     // regime run turned into a leading-zero run
   logic [c_CW-1:0]    w_m;       // run length m
   logic               w_found;
   logic [c_RW-1:0]    w_rem;     // exponent+fraction bits, left-aligned
   logic [SCALE_W-1:0] w_m_s;
   logic [SCALE_W-1:0] w_exp_s;
   logic [SCALE_W-1:0] w_scale;
   logic [c_VW-1:0]    w_s2_next;

   assign w_r   = r_s1_abs[c_AW-1];
   assign w_run = w_r ? ~r_s1_abs : r_s1_abs;

   // Leading-zero count of w_run. Its MSB is always 0, so m is at least 1;
   // an all-zero run (all regime bits) gives m = NBITS-1.
   always_comb begin
      w_m     = c_CW'(c_AW);
      w_found = 1'b0;
      for (int i = c_AW - 1; i >= 0; i--) begin
         if (!w_found && w_run[i]) begin
            w_m     = c_CW'(c_AW - 1 - i);
            w_found = 1'b1;
         end
      end
   end

   // The top two magnitude bits are always regime (run start) or terminator,
   // so only the low c_RW bits can carry exponent/fraction. Shifting them by
   // m-1 pushes the rest of the run and the terminator out the top.
   assign w_rem   = r_s1_abs[c_RW-1:0] << (w_m - c_CW'(1));
   assign w_m_s   = SCALE_W'(w_m);
   assign w_exp_s = SCALE_W'(w_rem[c_RW-1 -: ES]);

   // scale = 4*k + e with k = m-1 (r=1) or -m (r=0)
   assign w_scale = w_r ? (((w_m_s - SCALE_W'(1)) << ES) + w_exp_s)
                        : (w_exp_s - (w_m_s << ES));

   assign w_s2_next = (r_s1_zero | r_s1_inf)
                    ? {{(c_VW-2){1'b0}}, r_s1_inf, r_s1_zero}
                    : {r_s1_sgn, w_scale, w_rem[FBITS-1:0], 2'b00};

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sgn   <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_inf   <= 1'b0;
         r_s1_abs   <= '0;
      end else if (w_in_fire) begin
         r_s1_valid <= 1'b1;
         r_s1_sgn   <= bus.in_posit[NBITS-1];
         r_s1_zero  <= w_in_zero;
         r_s1_inf   <= w_in_inf;
         r_s1_abs   <= w_in_abs;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_value <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= 1'b1;
         r_s2_value <= w_s2_next;
      end else if (bus.out_ready) begin
         r_s2_valid <= 1'b0;
      end
   end
endmodule
`default_nettype wire
